des_round_ctrl: RTL and testbench
=================================

Name: des_round_ctrl

Overview:
Iterative DES engine controller that sequences the existing combinational f-function (expansion, S-boxes, straight P-box) over 16 rounds, one round per clock. It owns the L/R round registers, the C/D key-schedule registers, the IP/FP/PC1/PC2 wiring and the per-round shift schedule. It exposes valid/ready handshakes on both the block input and the result output.

Parameters:
None (the DES geometry is fixed).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  data_in/key_in/decrypt are valid
in_ready  output  1  block accepts a new job
data_in  input  64  plaintext or ciphertext; DES bit 1 = data_in[63]
key_in  input  64  DES key incl. parity bits; DES bit 1 = key_in[63]
decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept
out_valid  output  1  data_out is valid
out_ready  input  1  consumer takes data_out
data_out  output  64  result; DES bit 1 = data_out[63]
f_r  output  32  current R to the f-function; DES bit 1 at index 0
f_k  output  48  current subkey to the f-function; DES bit 1 at index 0
f_out  input  32  f-function result, same combinationally; DES bit 1 at index 0
round_idx  output  4  current round minus 1 (0..15); 0 when not in ROUND

Behaviour:
- Reset, asynchronous, rst_n low. Effects:
  - state=IDLE; in_ready=1; out_valid=0; data_out=0; round_idx=0.
  - L, R, C, D and the mode registers are cleared.
  - Reset mid-job discards the job; no output is produced.
- States are IDLE, ROUND and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - {L,R} <= IP(data_in).
    - {C,D} <= PC1(key_in), then the first-round shift is applied (see key schedule).
    - mode <= decrypt; round_idx <= 0; go to ROUND.
- ROUND:
  - in_ready=0. in_valid is ignored and not queued.
  - Each cycle: L <= R; R <= L ^ f_out; round_idx increments; the key-schedule shift for the next round is applied.
  - f_r = R. f_k = PC2(C,D) for the current round.
  - After round_idx=15 completes, go to DONE.
  - On that last update, data_out <= FP({R16,L16}): the final swap comes before FP.
- DONE:
  - out_valid=1. data_out holds stable until out_ready is high.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
  - in_ready is 0 in DONE, so there is no overlap. Minimum job period is 18 cycles.
- Latency: an accept on edge N gives out_valid=1 after edge N+16.
- Key schedule, encrypt:
  - Before round i, C and D rotate left by 1 for i in {1,2,9,16} and by 2 otherwise.
  - The round-1 shift is applied at load.
- Key schedule, decrypt:
  - Round 1 uses PC2(PC1 key) unshifted.
  - Before round i>1, C and D rotate right by 1 for i in {2,9,16} and by 2 otherwise.
  - After 16 rounds C/D equal their loaded value in both modes.
- Key bits: parity bits key_in[56,48,...,0] are ignored by PC1.
- f interface bit order: this block performs the bit reversal between standard order (MSB = DES bit 1) and f-function order (index 0 = DES bit 1).
- out_ready asserted while not DONE has no effect.

Optional Feature:
- Macro DES_ROUND_CTRL_ABORT_EN.
- Defined:
  - Adds port abort (input, 1).
  - abort high in ROUND or DONE forces state=IDLE, out_valid=0, round_idx=0 on the next edge. data_out is left unchanged.
  - abort has priority over the out_ready handshake in the same cycle.
  - abort in IDLE has no effect. A job accept in the same cycle as abort is allowed, with the accept taking effect.
- Undefined: the port does not exist and jobs always run to completion.

Test Plan:
- Encrypt: key 133457799BBCDFF1, data 0123456789ABCDEF, decrypt=0, out_ready=1 → out_valid exactly 16 cycles after accept, data_out=85E813540F0AB405.
- Decrypt: same key, data 85E813540F0AB405, decrypt=1 → data_out=0123456789ABCDEF.
- Backpressure: out_ready=0 for 10 cycles after completion → out_valid held, data_out stable, in_ready=0; a pulse of in_valid is ignored. out_ready=1 → IDLE next cycle.
- Subkey and round_idx check: trace f_k against K1..K16 for key 133457799BBCDFF1 (K1=1B02EFFC7072 in standard order); round_idx steps 0..15. Repeat in decrypt mode with K16..K1.
- Reset mid-job: rst_n low at round 7 → in_ready=1 and out_valid=0 immediately. A following encrypt job gives the correct result.
- With DES_ROUND_CTRL_ABORT_EN: abort at round 5 → IDLE, no out_valid. A following job with key 0E329232EA6D0D73, data 8787878787878787 → data_out=0000000000000000.

Source files
------------

// File: rtl/des_round_ctrl.sv
// des_round_ctrl -- iterative DES round controller.
//
// Sequences an external combinational f-function (E, S-boxes, P) over
// 16 rounds, one round per clock. Owns the L/R round registers, the C/D
// key-schedule registers, the IP/FP/PC1/PC2 wiring and the shift schedule.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     job handshake for data_in, key_in, decrypt
//   data_in, key_in       64-bit block and key, DES bit 1 = [63]
//   decrypt               0 = encrypt, 1 = decrypt (sampled on accept)
//   out_valid/out_ready   result handshake for data_out (DES bit 1 = [63])
//   f_r, f_k              R and subkey to the f-function, DES bit 1 = [0]
//   f_out                 f-function result, DES bit 1 = [0]
//   round_idx             current round - 1 while in ROUND, else 0
//   abort                 only with DES_ROUND_CTRL_ABORT_EN defined: drops
//                         the running job (ROUND or DONE) back to IDLE
//
// Build option: `define DES_ROUND_CTRL_ABORT_EN adds the abort port.

module des_round_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic [31:0] f_r,
    output logic [47:0] f_k,
    input  logic [31:0] f_out,
`ifdef DES_ROUND_CTRL_ABORT_EN
    input  logic        abort,
`endif
    output logic [3:0]  round_idx
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    // Tables hold DES bit numbers (1 = MSB of the standard-order vector).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    // Parity bits 8,16,...,64 never appear here, so they are dropped.
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
        return y;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[j] = x[31-j];
        return y;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[j] = x[47-j];
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        mode_q, mode_d;
    logic [3:0]  round_q, round_d;
    logic [63:0] data_out_q, data_out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            mode_q     <= 1'b0;
            round_q    <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            r_q        <= r_d;
            c_q        <= c_d;
            d_q        <= d_d;
            mode_q     <= mode_d;
            round_q    <= round_d;
            data_out_q <= data_out_d;
        end
    end

    logic [55:0] pc1_key;
    logic [31:0] f_std;
    logic        shift_one;
    logic [63:0] ip_data;

    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        r_d        = r_q;
        c_d        = c_q;
        d_d        = d_q;
        mode_d     = mode_q;
        round_d    = round_q;
        data_out_d = data_out_q;

        pc1_key = pc1_perm(key_in);
        ip_data = ip_perm(data_in);
        f_std   = rev32(f_out);
        // Single-bit shift before rounds 2, 9, 16; the extra step after
        // round 16 returns C/D to their load value in both directions.
        shift_one = (round_q == 4'd0) || (round_q == 4'd7) ||
                    (round_q == 4'd14) || (round_q == 4'd15);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    l_d     = ip_data[63:32];
                    r_d     = ip_data[31:0];
                    // Encrypt pre-applies the round-1 shift; decrypt starts
                    // on the unshifted key, which is K16.
                    c_d     = decrypt ? pc1_key[55:28] : rotl(pc1_key[55:28], 1'b0);
                    d_d     = decrypt ? pc1_key[27:0]  : rotl(pc1_key[27:0],  1'b0);
                    mode_d  = decrypt;
                    round_d = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                l_d     = r_q;
                r_d     = l_q ^ f_std;
                c_d     = mode_q ? rotr(c_q, !shift_one) : rotl(c_q, !shift_one);
                d_d     = mode_q ? rotr(d_q, !shift_one) : rotl(d_q, !shift_one);
                round_d = round_q + 4'd1;
                if (round_q == 4'd15) begin
                    // Final swap: output is FP(R16 || L16).
                    data_out_d = fp_perm({l_q ^ f_std, r_q});
                    round_d    = '0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DES_ROUND_CTRL_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            round_d    = '0;
            data_out_d = data_out_q;
        end
`endif
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign data_out  = data_out_q;
    assign round_idx = round_q;
    assign f_r       = rev32(r_q);
    assign f_k       = rev48(pc2_perm({c_q, d_q}));

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: models the external f-function, drives jobs
// from a vector table plus hand-written corner sequences, and checks
// results through a scoreboard queue filled on accept.
module tb_des_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] data_out;
    logic [31:0] f_r;
    logic [47:0] f_k;
    logic [31:0] f_out;
    logic [3:0]  round_idx;
`ifdef DES_ROUND_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif

    des_round_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key_in(key_in), .decrypt(decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .f_r(f_r), .f_k(f_k), .f_out(f_out),
`ifdef DES_ROUND_CTRL_ABORT_EN
        .abort(abort),
`endif
        .round_idx(round_idx));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- f-function model (standard order, bit 1 = MSB) -------
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5,   4, 5, 6, 7, 8, 9,   8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,  16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9,     19, 13, 30, 6, 22, 11, 4, 25};
    localparam int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[j] = x[31-j];
        return y;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[j] = x[47-j];
        return y;
    endfunction

    function automatic logic [31:0] f_std(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        logic [5:0]  six;
        int          v;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = e[47-6*b -: 6];
            v = SB[b][(six[5] ? 32 : 0) + (six[0] ? 16 : 0) + int'(six[4:1])];
            s[31-4*b -: 4] = v[3:0];
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    always_comb f_out = rev32(f_std(rev32(f_r), rev48(f_k)));

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected DUT event", nm);
    endtask

    typedef struct {
        logic [63:0] data;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] cur_exp = '0;
    logic        prev_ov = 1'b0;

    // Scoreboard: push on accept, pop on result handshake, flush on reset/abort.
    always @(negedge clk) begin
        exp_t e;
        logic flush;
        flush = 1'b0;
`ifdef DES_ROUND_CTRL_ABORT_EN
        flush = abort && !in_ready;
`endif
        if (!rst_n) begin
            sb.delete();
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) fail_now("out_valid_without_job");
                else chk("latency", 64'(cyc - sb[0].acc), 64'd16);
            end
            if (flush) sb.delete();
            else if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_out", data_out, e.data);
            end
            if (in_valid && in_ready) sb.push_back('{cur_exp, cyc + 1});
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_job(input logic [63:0] k, input logic [63:0] d,
                             input logic dec, input logic [63:0] e);
        int n = 0;
        @(posedge clk); #1;
        key_in = k; data_in = d; decrypt = dec; cur_exp = e; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) fail_now("accept");
        @(posedge clk); #1;
        // Scramble inputs so a design that keeps sampling them is caught.
        in_valid = 1'b0; key_in = ~k; data_in = ~d; decrypt = ~dec;
    endtask

    task automatic wait_ov(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin @(negedge clk); n++; end
        if (!out_valid) fail_now("wait_out_valid");
    endtask

    task automatic run_job(input logic [63:0] k, input logic [63:0] d,
                           input logic dec, input logic [63:0] e);
        start_job(k, d, dec, e);
        wait_ov(20);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;

    vec_t        vecs [10];
    logic [47:0] ks [16];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{KEY, PT, 1'b0, CT},
            '{KEY, CT, 1'b1, PT},
            '{64'h123556789ABDDEF0, PT, 1'b0, CT},   // parity bits flipped
            '{64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7},
            '{64'h0, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0},
            '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58},
            '{64'h3000000000000000, 64'h1000000000000001, 1'b0, 64'h958E6E627A05557B},
            '{64'h1111111111111111, 64'h1111111111111111, 1'b0, 64'hF40379AB9E0EC533},
            '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0},
            '{64'h0E329232EA6D0D73, 64'h0, 1'b1, 64'h8787878787878787}};
        ks = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
               48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
               48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
               48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

        // Reset state
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_round_idx", 64'(round_idx), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors
        for (int i = 0; i < 10; i++)
            run_job(vecs[i].key, vecs[i].data, vecs[i].dec, vecs[i].exp);

        // Subkey / round_idx trace, encrypt then decrypt
        for (int m = 0; m < 2; m++) begin
            start_job(KEY, (m == 0) ? PT : CT, m[0], (m == 0) ? CT : PT);
            for (int r = 0; r < 16; r++) begin
                @(negedge clk);
                chk("round_idx", 64'(round_idx), 64'(r));
                chk(m == 0 ? "subkey_enc" : "subkey_dec", 64'(rev48(f_k)),
                    64'(ks[m == 0 ? r : 15 - r]));
                if (r == 8) chk("round_in_ready", 64'(in_ready), 64'd0);
            end
            @(negedge clk);
            chk("done_out_valid", 64'(out_valid), 64'd1);
            chk("done_round_idx", 64'(round_idx), 64'd0);
            @(posedge clk); #1;
        end

        // Backpressure with an ignored in_valid pulse
        out_ready = 1'b0;
        start_job(KEY, PT, 1'b0, CT);
        wait_ov(20);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = (i == 3);
            data_in  = 64'hDEADBEEFDEADBEEF;
            cur_exp  = 64'hBADBADBADBADBAD0;
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_data_out", data_out, CT);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        repeat (20) @(negedge clk);
        chk("bp_no_ghost_job", 64'(out_valid), 64'd0);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset in the middle of a job
        start_job(KEY, PT, 1'b0, CT);
        repeat (8) @(negedge clk);
        chk("mid_round_idx", 64'(round_idx), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_round_idx", 64'(round_idx), 64'd0);
        chk("mid_rst_data_out", data_out, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_output", 64'(out_valid), 64'd0);
        run_job(KEY, PT, 1'b0, CT);

`ifdef DES_ROUND_CTRL_ABORT_EN
        // Abort at round 5 discards the job
        start_job(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        chk("abort_round_idx", 64'(round_idx), 64'd5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_round_idx0", 64'(round_idx), 64'd0);
        chk("abort_data_out_kept", data_out, CT);
        repeat (20) @(negedge clk);
        chk("abort_no_output", 64'(out_valid), 64'd0);
        run_job(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0);

        // Abort in IDLE together with an accept: the job still runs
        abort = 1'b1;
        start_job(KEY, PT, 1'b0, CT);
        abort = 1'b0;
        wait_ov(20);
        @(posedge clk); #1;
`endif

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
